// File: rtl/ibex_ex_seq_ctrl.sv
// rtl/ibex_ex_seq_ctrl.sv - execute-stage ALU/multdiv sequencer with intermediate registers
// Optional busy-cycle timeout enabled by defining IBEX_EX_SEQ_TIMEOUT_EN.
module ibex_ex_seq_ctrl #(
  parameter int RV32M     = 2,
  parameter int MaxCycles = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  input  logic [1:0]  req_kind_i,
  output logic        req_ready_o,
  output logic        alu_instr_first_cycle_o,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic        multdiv_ready_id_o,
  input  logic        ex_valid_i,
  input  logic [31:0] result_ex_i,
  input  logic [1:0]  imd_val_we_i,
  input  logic [67:0] imd_val_d_i,
  output logic [67:0] imd_val_q_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_error_o
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic        first_q, first_d;
  logic [31:0] result_q, result_d;
  logic        error_q, error_d;
  logic [67:0] imd_q;
  logic        accept, kind_legal, timeout;

  assign kind_legal  = (req_kind_i == 2'd0) || ((req_kind_i != 2'd3) && (RV32M != 0));
  assign req_ready_o = !flush_i && ((state_q == IDLE) || ((state_q == HOLD) && rsp_ready_i));
  assign accept      = req_valid_i && req_ready_o;

`ifdef IBEX_EX_SEQ_TIMEOUT_EN
  logic [7:0] cnt_q;

  // Counter sits at zero outside BUSY, so it is already clear on entry.
  assign timeout = (state_q == BUSY) && !ex_valid_i && ((cnt_q + 8'd1) == 8'(MaxCycles));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else if ((state_q != BUSY) || flush_i) begin
      cnt_q <= 8'd0;
    end else if (!ex_valid_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    result_d = result_q;
    error_d  = error_q;
    first_d  = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        BUSY: begin
          if (ex_valid_i) begin
            result_d = result_ex_i;
            error_d  = 1'b0;
            state_d  = HOLD;
          end else if (timeout) begin
            result_d = 32'd0;
            error_d  = 1'b1;
            state_d  = HOLD;
          end
        end
        HOLD: if (rsp_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // accept is already gated by flush_i through req_ready_o.
    if (accept) begin
      kind_d = req_kind_i;
      if (kind_legal) begin
        state_d = BUSY;
        first_d = 1'b1;
      end else begin
        state_d  = HOLD;
        result_d = 32'd0;
        error_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      kind_q   <= 2'd0;
      first_q  <= 1'b0;
      result_q <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      first_q  <= first_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imd_q <= 68'd0;
    end else if ((state_q == BUSY) && !flush_i) begin
      if (imd_val_we_i[0]) imd_q[33:0]  <= imd_val_d_i[33:0];
      if (imd_val_we_i[1]) imd_q[67:34] <= imd_val_d_i[67:34];
    end
  end

  assign alu_instr_first_cycle_o = first_q;
  assign multdiv_ready_id_o      = (state_q == BUSY);
  assign mult_en_o               = (state_q == BUSY) && (kind_q == 2'd1);
  assign mult_sel_o              = (state_q == BUSY) && (kind_q == 2'd1);
  assign div_en_o                = (state_q == BUSY) && (kind_q == 2'd2);
  assign div_sel_o               = (state_q == BUSY) && (kind_q == 2'd2);
  assign rsp_valid_o             = (state_q == HOLD);
  assign rsp_result_o            = result_q;
  assign rsp_error_o             = error_q;
  assign imd_val_q_o             = imd_q;

endmodule

// File: tb/tb_ibex_ex_seq_ctrl.sv
// tb/tb_ibex_ex_seq_ctrl.sv - randomized transaction-level check of ibex_ex_seq_ctrl
module tb_ibex_ex_seq_ctrl;
  localparam int MAXC = 4;

  logic clk = 1'b0;
  logic rst, flush, req_valid, req_valid0, ex_valid, rsp_ready;
  logic [1:0] req_kind, imd_we;
  logic [31:0] result_ex;
  logic [67:0] imd_d;

  logic req_ready, first, mult_en, div_en, mult_sel, div_sel, md_ready, rsp_valid, rsp_error;
  logic [67:0] imd_q;
  logic [31:0] rsp_result;
  logic req_ready0, first0, mult_en0, div_en0, mult_sel0, div_sel0, md_ready0, rsp_valid0, rsp_error0;
  logic [67:0] imd_q0;
  logic [31:0] rsp_result0;

  int n_chk = 0;
  int n_fail = 0;
  logic [33:0] imd_m [2];

  always #5 clk = ~clk;

  ibex_ex_seq_ctrl #(.RV32M(2), .MaxCycles(MAXC)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid), .req_kind_i(req_kind),
    .req_ready_o(req_ready), .alu_instr_first_cycle_o(first), .mult_en_o(mult_en), .div_en_o(div_en),
    .mult_sel_o(mult_sel), .div_sel_o(div_sel), .multdiv_ready_id_o(md_ready), .ex_valid_i(ex_valid),
    .result_ex_i(result_ex), .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(imd_q),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result), .rsp_error_o(rsp_error));

  ibex_ex_seq_ctrl #(.RV32M(0), .MaxCycles(MAXC)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid0), .req_kind_i(req_kind),
    .req_ready_o(req_ready0), .alu_instr_first_cycle_o(first0), .mult_en_o(mult_en0), .div_en_o(div_en0),
    .mult_sel_o(mult_sel0), .div_sel_o(div_sel0), .multdiv_ready_id_o(md_ready0), .ex_valid_i(ex_valid),
    .result_ex_i(result_ex), .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(imd_q0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result0), .rsp_error_o(rsp_error0));

  task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from an idle start: accept, busy phase, then response or flush.
  task automatic run_op(input logic [1:0] kind, input int lat, input int flush_at,
                        input bit ones, input int stall);
    logic [31:0] res_m;
    logic        err_m;
    bit          done, flushed;
    res_m = 32'd0;
    err_m = 1'b1;
    flushed = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_kind  = kind;
    #1 check_eq("accept_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    if (kind != 2'd3) begin
      done = 1'b0;
      for (int i = 1; !done; i++) begin
        ex_valid  = (i == lat);
        flush     = (i == flush_at);
        result_ex = $urandom;
        imd_we    = ones ? ((i <= 3) ? 2'b11 : 2'b00) : 2'($urandom_range(0, 3));
        imd_d     = ones ? {68{1'b1}} : {4'($urandom), $urandom, $urandom};
        #1;
        check_eq("first_cycle", first, (i == 1));
        check_eq("mult_en", {mult_en, mult_sel}, (kind == 2'd1) ? 2'b11 : 2'b00);
        check_eq("div_en", {div_en, div_sel}, (kind == 2'd2) ? 2'b11 : 2'b00);
        check_eq("busy_flags", {md_ready, rsp_valid, req_ready}, 3'b100);
        check_eq("imd_busy", imd_q, {imd_m[1], imd_m[0]});
        if (flush) begin
          flushed = 1'b1;
          done = 1'b1;
        end else begin
          if (imd_we[0]) imd_m[0] = imd_d[33:0];
          if (imd_we[1]) imd_m[1] = imd_d[67:34];
          if (ex_valid) begin
            res_m = result_ex;
            err_m = 1'b0;
            done  = 1'b1;
          end
`ifdef IBEX_EX_SEQ_TIMEOUT_EN
          else if (i == MAXC) begin
            done = 1'b1;
          end
`endif
        end
        @(negedge clk);
      end
      ex_valid = 1'b0;
      flush    = 1'b0;
      imd_we   = 2'b00;
    end
    if (flushed) begin
      #1;
      check_eq("flush_idle", {rsp_valid, md_ready, req_ready}, 3'b001);
      check_eq("imd_flush", imd_q, {imd_m[1], imd_m[0]});
    end else begin
      for (int s = 0; s < stall; s++) begin
        rsp_ready = 1'b0;
        #1 check_eq("hold_stall", {rsp_valid, req_ready, rsp_error, rsp_result}, {1'b1, 1'b0, err_m, res_m});
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1 check_eq("hold_rsp", {rsp_valid, req_ready, rsp_error, rsp_result}, {1'b1, 1'b1, err_m, res_m});
      check_eq("imd_hold", imd_q, {imd_m[1], imd_m[0]});
      @(negedge clk);
      rsp_ready = 1'b0;
      #1 check_eq("rsp_drop", rsp_valid, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; req_kind = 2'd0;
    ex_valid = 1'b0; result_ex = 32'd0; imd_we = 2'b00; imd_d = 68'd0; rsp_ready = 1'b0;
    imd_m[0] = 34'd0;
    imd_m[1] = 34'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_outs", {first, mult_en, div_en, mult_sel, div_sel, md_ready, rsp_valid, rsp_error, rsp_result}, 0);
    check_eq("rst_imd", imd_q, 0);
    rst = 1'b0;

    // ALU back-to-back
    @(negedge clk);
    req_valid = 1'b1; req_kind = 2'd0;
    #1 check_eq("b2b_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; ex_valid = 1'b1; result_ex = 32'h0000_1234;
    #1 check_eq("b2b_first", first, 1);
    @(negedge clk);
    ex_valid = 1'b0;
    #1 check_eq("b2b_rsp", {rsp_valid, rsp_error, rsp_result}, {2'b10, 32'h1234});
    rsp_ready = 1'b1; req_valid = 1'b1; req_kind = 2'd0;
    #1 check_eq("b2b_ready", req_ready, 1);
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    #1 check_eq("b2b_first2", {first, rsp_valid, md_ready}, 3'b101);
    ex_valid = 1'b1; result_ex = 32'hBEEF;
    @(negedge clk);
    ex_valid = 1'b0;
    #1 check_eq("b2b_rsp2", {rsp_valid, rsp_result}, {1'b1, 32'hBEEF});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 check_eq("b2b_done", rsp_valid, 0);

    // flush blocks acceptance
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_kind = 2'd1;
    #1 check_eq("flush_block", req_ready, 0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1 check_eq("flush_noacc", {md_ready, req_ready}, 2'b01);

    run_op(2'd2, 5, 0, 1'b1, 1);
    check_eq("div_ones", imd_q, {68{1'b1}});
    run_op(2'd2, 2, 2, 1'b0, 0);
    run_op(2'd3, 1, 0, 1'b0, 2);

    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      req_valid0 = 1'b1; req_kind = 2'(k);
      #1 check_eq("rv0_accept", req_ready0, 1);
      @(negedge clk);
      req_valid0 = 1'b0;
      #1 check_eq("rv0_err", {rsp_valid0, rsp_error0, rsp_result0}, {2'b11, 32'd0});
      check_eq("rv0_quiet", {first0, mult_en0, mult_sel0, div_en0, div_sel0, md_ready0}, 0);
      check_eq("rv0_imd", imd_q0, 0);
      rsp_ready = 1'b1;
      #1 check_eq("rv0_ready", req_ready0, 1);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1 check_eq("rv0_drop", rsp_valid0, 0);
    end

`ifdef IBEX_EX_SEQ_TIMEOUT_EN
    run_op(2'd1, 1000, 0, 1'b0, 0);
`else
    @(negedge clk);
    req_valid = 1'b1; req_kind = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (300) @(negedge clk);
    #1 check_eq("no_timeout", {md_ready, mult_en, rsp_valid}, 3'b110);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check_eq("no_timeout_flush", {md_ready, rsp_valid}, 2'b00);
`endif

    for (int n = 0; n < 60; n++) begin
      int lat;
      lat = $urandom_range(1, 7);
      run_op(2'($urandom_range(0, 3)), lat,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0,
             1'b0, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
